// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. It owns the PC and drives the
// instruction memory controls. It also tracks which PC belongs to the word
// now on the memory's registered output.
//
// state  | meaning
// BOOT   | first fetch after reset, nothing valid on Q yet
// RUN    | steady state, Q carries the word fetched last cycle
// BUBBLE | flushed slot on Q, redirect/exception target being read
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        exc,
    output logic        imem_cen,
    output logic [31:0] imem_a,
    output logic        imem_hold,
    output logic        imem_flush,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        if_valid,
    output logic        misalign,
    output logic [31:0] badvaddr
);

    localparam logic [1:0] BOOT   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] BUBBLE = 2'd2;

    logic [31:0] pc;
    logic [1:0]  state;
    logic        redir_bad;
    logic        to_vector;

    // A redirect to a non-word address is treated as an exception.
    assign redir_bad = redirect & (redirect_pc[1:0] != 2'b00);
    assign to_vector = exc | redir_bad;

    // Memory controls. A redirect or exception overrides a stall, so Hold
    // and Flush can never be high together.
    always_comb begin
        imem_cen   = ~rst;
        imem_a     = pc;
        imem_hold  = ~rst & stall & ~redirect & ~exc;
        imem_flush = ~rst & (redirect | exc);
        if_pc4     = if_pc + 32'd4;
    end

    // PC, Q tagging and FSM. Priority: rst, exc/misaligned, redirect, stall, advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            if_pc    <= RESET_PC;
            if_valid <= 1'b0;
            state    <= BOOT;
            misalign <= 1'b0;
            badvaddr <= 32'h0000_0000;
        end else begin
            misalign <= 1'b0;
            if (to_vector) begin
                pc       <= EXC_VECTOR;
                if_valid <= 1'b0;
                state    <= BUBBLE;
                if (!exc) begin
                    misalign <= 1'b1;
                    badvaddr <= redirect_pc;
                end
            end else if (redirect) begin
                pc       <= redirect_pc;
                if_valid <= 1'b0;
                state    <= BUBBLE;
            end else if (!stall) begin
                pc       <= pc + 32'd4;
                if_pc    <= pc;
                if_valid <= 1'b1;
                case (state)
                    BOOT:    state <= RUN;
                    RUN:     state <= RUN;
                    BUBBLE:  state <= RUN;
                    default: state <= RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table plus randomized run of fetch_unit. The
// instruction memory is modelled here. Its registered Q is used to confirm
// that the if_pc/if_valid tags match the word actually presented.
module tb_fetch_unit;

    typedef struct packed {
        logic        r;
        logic        s;
        logic        d;
        logic [31:0] rp;
        logic        e;
        logic        h;
        logic        f;
        logic [31:0] a;
        logic [31:0] ip;
        logic        vl;
        logic        m;
        logic [31:0] b;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, redirect, exc;
    logic [31:0] redirect_pc;

    logic        imem_cen, imem_hold, imem_flush, if_valid, misalign;
    logic [31:0] imem_a, if_pc, if_pc4, badvaddr;

    logic        w2_cen, w2_hold, w2_flush, w2_valid, w2_mis;
    logic [31:0] w2_a, w2_pc, w2_pc4, w2_bad;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .exc(exc),
        .imem_cen(imem_cen), .imem_a(imem_a), .imem_hold(imem_hold),
        .imem_flush(imem_flush), .if_pc(if_pc), .if_pc4(if_pc4),
        .if_valid(if_valid), .misalign(misalign), .badvaddr(badvaddr)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .exc(exc),
        .imem_cen(w2_cen), .imem_a(w2_a), .imem_hold(w2_hold),
        .imem_flush(w2_flush), .if_pc(w2_pc), .if_pc4(w2_pc4),
        .if_valid(w2_valid), .misalign(w2_mis), .badvaddr(w2_bad)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return {20'hABCDE, a[11:2], 2'b11};
    endfunction

    // Instruction memory: 1-cycle registered read with Hold and Flush.
    logic [31:0] q;
    always @(posedge clk) begin
        if (!imem_cen)       q <= 32'h0;
        else if (imem_flush) q <= 32'h0;
        else if (!imem_hold) q <= word(imem_a);
    end

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t v(input logic r, input logic s, input logic d,
                               input logic [31:0] rp, input logic e,
                               input logic h, input logic f,
                               input logic [31:0] a, input logic [31:0] ip,
                               input logic vl, input logic m, input logic [31:0] b);
        vec_t t;
        t.r = r; t.s = s; t.d = d; t.rp = rp; t.e = e;
        t.h = h; t.f = f; t.a = a; t.ip = ip; t.vl = vl; t.m = m; t.b = b;
        return t;
    endfunction

    task automatic run_cycle(input vec_t t, input string tag);
        rst = t.r; stall = t.s; redirect = t.d; redirect_pc = t.rp; exc = t.e;
        #1;
        chk({tag, " cen"},   32'(imem_cen),   32'(!t.r));
        chk({tag, " hold"},  32'(imem_hold),  32'(t.h));
        chk({tag, " flush"}, 32'(imem_flush), 32'(t.f));
        @(posedge clk);
        #1;
        chk({tag, " imem_a"},   imem_a,         t.a);
        chk({tag, " if_valid"}, 32'(if_valid),  32'(t.vl));
        chk({tag, " misalign"}, 32'(misalign),  32'(t.m));
        chk({tag, " badvaddr"}, badvaddr,       t.b);
        if (t.vl) begin
            chk({tag, " if_pc"},  if_pc,  t.ip);
            chk({tag, " if_pc4"}, if_pc4, t.ip + 32'd4);
            chk({tag, " q_word"}, q,      word(t.ip));
        end
        if (t.f) chk({tag, " q_nop"}, q, 32'h0);
    endtask

    vec_t        tbl[26];
    logic [31:0] wrap_exp[3];

    logic [31:0] m_pc, m_ifpc, m_bad;
    logic        m_valid, m_mis;

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; exc = 1'b0;

        //             r     s     d     rp            e     h     f     a             ip            vl    m     b
        tbl[0]  = v(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0);
        tbl[1]  = v(1'b1, 1'b1, 1'b1, 32'h40,       1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0);
        tbl[2]  = v(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h4,        32'h0,        1'b1, 1'b0, 32'h0);
        tbl[3]  = v(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h8,        32'h4,        1'b1, 1'b0, 32'h0);
        tbl[4]  = v(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'hC,        32'h8,        1'b1, 1'b0, 32'h0);
        tbl[5]  = v(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h10,       32'hC,        1'b1, 1'b0, 32'h0);
        tbl[6]  = v(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h10,       32'hC,        1'b1, 1'b0, 32'h0);
        tbl[7]  = v(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h10,       32'hC,        1'b1, 1'b0, 32'h0);
        tbl[8]  = v(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h10,       32'hC,        1'b1, 1'b0, 32'h0);
        tbl[9]  = v(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h14,       32'h10,       1'b1, 1'b0, 32'h0);
        tbl[10] = v(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h18,       32'h14,       1'b1, 1'b0, 32'h0);
        tbl[11] = v(1'b0, 1'b0, 1'b1, 32'h40,       1'b0, 1'b0, 1'b1, 32'h40,       32'h0,        1'b0, 1'b0, 32'h0);
        tbl[12] = v(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h44,       32'h40,       1'b1, 1'b0, 32'h0);
        tbl[13] = v(1'b0, 1'b0, 1'b1, 32'h42,       1'b0, 1'b0, 1'b1, 32'h180,      32'h0,        1'b0, 1'b1, 32'h42);
        tbl[14] = v(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h184,      32'h180,      1'b1, 1'b0, 32'h42);
        tbl[15] = v(1'b0, 1'b1, 1'b1, 32'h80,       1'b1, 1'b0, 1'b1, 32'h180,      32'h0,        1'b0, 1'b0, 32'h42);
        tbl[16] = v(1'b0, 1'b1, 1'b1, 32'h80,       1'b0, 1'b0, 1'b1, 32'h80,       32'h0,        1'b0, 1'b0, 32'h42);
        tbl[17] = v(1'b0, 1'b0, 1'b1, 32'h100,      1'b0, 1'b0, 1'b1, 32'h100,      32'h0,        1'b0, 1'b0, 32'h42);
        tbl[18] = v(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h104,      32'h100,      1'b1, 1'b0, 32'h42);
        tbl[19] = v(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h104,      32'h100,      1'b1, 1'b0, 32'h42);
        tbl[20] = v(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0);
        tbl[21] = v(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h4,        32'h0,        1'b1, 1'b0, 32'h0);
        tbl[22] = v(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h180,      32'h0,        1'b0, 1'b0, 32'h0);
        tbl[23] = v(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0);
        tbl[24] = v(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0);
        tbl[25] = v(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h4,        32'h0,        1'b1, 1'b0, 32'h0);

        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;

        for (int i = 0; i < 26; i++) begin
            run_cycle(tbl[i], $sformatf("tbl%0d", i));
            if (i >= 2 && i <= 4) begin
                chk($sformatf("wrap%0d if_pc", i),    w2_pc,         wrap_exp[i-2]);
                chk($sformatf("wrap%0d if_pc4", i),   w2_pc4,        wrap_exp[i-2] + 32'd4);
                chk($sformatf("wrap%0d if_valid", i), 32'(w2_valid), 32'd1);
                chk($sformatf("wrap%0d misalign", i), 32'(w2_mis),   32'd0);
            end
        end

        // Randomized traffic checked against an event-level model of the fetch stage.
        m_pc = 32'h0; m_ifpc = 32'h0; m_bad = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            logic        r, s, d, e, h, f;
            logic [31:0] rp;
            r  = (i == 0) || ($urandom_range(0, 63) == 0);
            e  = ($urandom_range(0, 15) == 0);
            d  = ($urandom_range(0, 7) == 0);
            s  = ($urandom_range(0, 3) == 0);
            rp = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) rp[1:0] = 2'($urandom_range(1, 3));
            h  = !r && s && !d && !e;
            f  = !r && (d || e);
            if (r) begin
                m_pc = 32'h0; m_ifpc = 32'h0; m_valid = 1'b0; m_mis = 1'b0; m_bad = 32'h0;
            end else if (e) begin
                m_pc = 32'h180; m_valid = 1'b0; m_mis = 1'b0;
            end else if (d && rp[1:0] != 2'b00) begin
                m_pc = 32'h180; m_valid = 1'b0; m_mis = 1'b1; m_bad = rp;
            end else if (d) begin
                m_pc = rp; m_valid = 1'b0; m_mis = 1'b0;
            end else if (s) begin
                m_mis = 1'b0;
            end else begin
                m_ifpc = m_pc; m_pc = m_pc + 32'd4; m_valid = 1'b1; m_mis = 1'b0;
            end
            run_cycle(v(r, s, d, rp, e, h, f, m_pc, m_ifpc, m_valid, m_mis, m_bad),
                      $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
